estacao_vedacao: RTL and testbench
==================================

# estacao_vedacao

Cork-sealing station controller for the bottling line, directly downstream of the cork tray. It detects a bottle arriving at the sealing position and withdraws one cork from the tray with a single-cycle pulse. It then drives the seal actuator for a fixed time, releases the bottle and keeps a BCD count of sealed bottles. It consumes the tray's CR/BZ flags, stalls the line when the tray is empty, and generates the tray's `reabastecer` pulse when the operator confirms a refill.

## Interface
- `SEAL_CYCLES`, default 4: cycles `vedar` is held high per bottle; legal range 1..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `garrafa_pos`  in  1  bottle-in-position sensor, level; a new bottle is a 0->1 transition.
- `CR`  in  1  from tray: five corks remain.
- `BZ`  in  1  from tray: zero corks remain.
- `refill_ok`  in  1  operator refill confirmation, level or pulse.
- `pega_rolha`  out  1  one-cycle pulse; the tray decrements by exactly one cork per pulse.
- `vedar`  out  1  seal actuator drive.
- `libera`  out  1  one-cycle pulse: bottle sealed, conveyor may advance.
- `reabastecer`  out  1  one-cycle pulse to the tray: +20 corks.
- `alarme_cr`  out  1  low-cork warning, registered copy of `CR`.
- `parado`  out  1  high while stalled on an empty tray.
- `unidades_vedadas`  out  4  BCD units of the sealed-bottle count.
- `dezenas_vedadas`  out  4  BCD tens of the sealed-bottle count.

## Operation
- **Rising-edge detection.** `garrafa_pos` is registered as `prev`. `rise = garrafa_pos & ~prev`.
- **Pending flag.** `pendente` holds at most one bottle request.
  - Set on `rise` in any state other than IDLE-with-transition-taken.
  - Cleared on entry to PEGA.
  - A `rise` while `pendente` is already 1 is dropped.
- **FSM states:** IDLE, PEGA, VEDA, LIBERA, ESPERA, REABAST, ASSENTA.
- **IDLE**
  - `BZ` = 1 -> ESPERA. This has priority over any bottle request.
  - Else `rise | pendente` -> PEGA.
  - Else `refill_ok & alarme_cr` -> REABAST (early refill).
- **PEGA:** `pega_rolha` = 1 for one cycle -> VEDA.
- **VEDA:** `vedar` = 1. A 4-bit timer counts `SEAL_CYCLES` cycles, then -> LIBERA.
- **LIBERA:** `libera` = 1 for one cycle. BCD count += 1 -> IDLE.
- **ESPERA:** `parado` = 1. `refill_ok` -> REABAST. `garrafa_pos` rises are still latched into `pendente`.
- **REABAST:** `reabastecer` = 1 for one cycle -> ASSENTA.
- **ASSENTA:** one settle cycle so that the tray's `BZ`/`CR` reflect the refill -> IDLE.
- **Input gating:** `refill_ok` is ignored in all states except ESPERA, and IDLE with `alarme_cr` = 1.
- **BCD counter**
  - Units 0..9. When units wrap from 9 to 0, tens increment.
  - 99 -> 00, with no overflow flag.
  - Values above 9 are never produced.
- **Output registration:** all outputs are decoded from registered state (Moore) or are registers themselves. There are no combinational paths from inputs to outputs.
- **Reset (`reset` = 0 at an edge)**
  - State -> IDLE; `prev`, `pendente` and the timer -> 0.
  - Count -> 00. Every output -> 0.
  - Reset mid-operation abandons the bottle. No `libera` is issued and the count is not incremented.

## Timing
- A rise sampled at edge n -> `pega_rolha` high in cycle n+1, provided the FSM is in IDLE and `BZ` = 0.
- `vedar` is high for cycles n+2 .. n+1+SEAL_CYCLES.
- `libera` is high in cycle n+2+SEAL_CYCLES. The count is updated and visible from cycle n+3+SEAL_CYCLES.
- Minimum service period: SEAL_CYCLES+3 cycles per bottle, including one IDLE cycle.
- `alarme_cr` lags `CR` by 1 cycle.
- `parado` is high from the cycle after IDLE samples `BZ` = 1 until the cycle REABAST is entered.
- `refill_ok` sampled in ESPERA at edge m:
  - `reabastecer` high in cycle m+1.
  - ASSENTA in cycle m+2.
  - IDLE in cycle m+3, where a pending bottle is serviced if `BZ` = 0.
- If `BZ` is still 1 after ASSENTA, the FSM returns to ESPERA. The FSM never loops PEGA on an empty tray.
- `pega_rolha` and `reabastecer` are never high in the same cycle.

## Test plan
- Reset: hold `reset` = 0 for 1 edge with random inputs -> all outputs 0 and count 00 in the next cycle.
- Single bottle, SEAL_CYCLES = 4: rise at edge 0 ->
  - `pega_rolha` in cycle 1;
  - `vedar` in cycles 2-5;
  - `libera` in cycle 6;
  - count = 01 from cycle 7.
- Empty tray: `BZ` = 1 with a bottle rise -> `parado` = 1 and no `pega_rolha`. Pulse `refill_ok`, then drop `BZ` ->
  - `reabastecer` = 1 for exactly 1 cycle;
  - after ASSENTA the pending bottle gets `pega_rolha`;
  - `parado` = 0.
- Pending and drop: rises during VEDA, then again during LIBERA -> exactly one extra bottle is serviced immediately after IDLE; the count advances by 2 in total.
- Wrap: service 100 bottles -> count reads 99 after the 99th bottle and 00 after the 100th; units never exceed 9.
- Reset mid-VEDA -> `vedar` = 0 in the next cycle, no `libera`, count = 00, state IDLE. A subsequent rise is serviced normally.

Source files
------------

// File: rtl/estacao_vedacao.sv
// Cork-sealing station controller: withdraws one cork per bottle, drives the seal
// actuator for SEAL_CYCLES, releases the bottle and keeps a two-digit BCD count.
module estacao_vedacao #(
  parameter int SEAL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       garrafa_pos,
  input  logic       CR,
  input  logic       BZ,
  input  logic       refill_ok,
  output logic       pega_rolha,
  output logic       vedar,
  output logic       libera,
  output logic       reabastecer,
  output logic       alarme_cr,
  output logic       parado,
  output logic [3:0] unidades_vedadas,
  output logic [3:0] dezenas_vedadas
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PEGA    = 3'd1,
    VEDA    = 3'd2,
    LIBERA  = 3'd3,
    ESPERA  = 3'd4,
    REABAST = 3'd5,
    ASSENTA = 3'd6
  } state_t;

  localparam logic [3:0] SEAL_LAST = 4'(SEAL_CYCLES - 1);

  state_t     state_r;
  state_t     state_next_s;
  logic       prev_r;
  logic       rise_s;
  logic       pendente_r;
  logic       pendente_next_s;
  logic [3:0] timer_r;
  logic [3:0] timer_next_s;
  logic [7:0] count_r;

  // Two-digit BCD increment; 99 wraps to 00 and no digit ever exceeds 9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value);
    logic [3:0] units;
    logic [3:0] tens;
    units = value[3:0];
    tens  = value[7:4];
    if (units >= 4'd9) begin
      units = 4'd0;
      if (tens >= 4'd9) begin
        tens = 4'd0;
      end else begin
        tens = tens + 4'd1;
      end
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  assign rise_s = garrafa_pos & ~prev_r;

  // Next-state, seal timer and pending-bottle decode.
  always_comb begin
    state_next_s    = state_r;
    timer_next_s    = 4'd0;
    pendente_next_s = pendente_r;
    case (state_r)
      IDLE: begin
        // An empty tray wins over any bottle request so PEGA never runs dry.
        if (BZ) begin
          state_next_s = ESPERA;
        end else if (rise_s | pendente_r) begin
          state_next_s = PEGA;
        end else if (refill_ok & alarme_cr) begin
          state_next_s = REABAST;
        end else begin
          state_next_s = IDLE;
        end
      end
      PEGA: begin
        state_next_s = VEDA;
      end
      VEDA: begin
        if (timer_r == SEAL_LAST) begin
          state_next_s = LIBERA;
        end else begin
          timer_next_s = timer_r + 4'd1;
        end
      end
      LIBERA: begin
        state_next_s = IDLE;
      end
      ESPERA: begin
        if (refill_ok) begin
          state_next_s = REABAST;
        end else begin
          state_next_s = ESPERA;
        end
      end
      REABAST: begin
        state_next_s = ASSENTA;
      end
      ASSENTA: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    // A rise that directly starts service is consumed; otherwise it is remembered once.
    if (state_next_s == PEGA) begin
      pendente_next_s = 1'b0;
    end else if (rise_s) begin
      pendente_next_s = 1'b1;
    end else begin
      pendente_next_s = pendente_r;
    end
  end

  // State, edge detector, counter and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      prev_r      <= 1'b0;
      pendente_r  <= 1'b0;
      timer_r     <= 4'd0;
      count_r     <= 8'h00;
      alarme_cr   <= 1'b0;
      pega_rolha  <= 1'b0;
      vedar       <= 1'b0;
      libera      <= 1'b0;
      reabastecer <= 1'b0;
      parado      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      prev_r      <= garrafa_pos;
      pendente_r  <= pendente_next_s;
      timer_r     <= timer_next_s;
      alarme_cr   <= CR;
      pega_rolha  <= (state_next_s == PEGA);
      vedar       <= (state_next_s == VEDA);
      libera      <= (state_next_s == LIBERA);
      reabastecer <= (state_next_s == REABAST);
      parado      <= (state_next_s == ESPERA);
      if (state_r == LIBERA) begin
        count_r <= bcd_inc(count_r);
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign unidades_vedadas = count_r[3:0];
  assign dezenas_vedadas  = count_r[7:4];

endmodule

// File: tb/tb_estacao_vedacao.sv
// Directed bench for estacao_vedacao: expected output vectors are queued as stimulus
// is planned and popped/compared once per cycle on the falling edge.
module tb_estacao_vedacao;

  localparam int SEAL = 4;
  // Flag order: {pega_rolha, vedar, libera, reabastecer, parado, alarme_cr}
  localparam logic [5:0] F_IDLE = 6'b000000;
  localparam logic [5:0] F_PEGA = 6'b100000;
  localparam logic [5:0] F_VEDA = 6'b010000;
  localparam logic [5:0] F_LIB  = 6'b001000;
  localparam logic [5:0] F_REAB = 6'b000100;
  localparam logic [5:0] F_PAR  = 6'b000010;
  localparam logic [5:0] F_ALM  = 6'b000001;

  logic       clk = 1'b0;
  logic       reset;
  logic       garrafa_pos;
  logic       CR;
  logic       BZ;
  logic       refill_ok;
  logic       pega_rolha;
  logic       vedar;
  logic       libera;
  logic       reabastecer;
  logic       alarme_cr;
  logic       parado;
  logic [3:0] unidades_vedadas;
  logic [3:0] dezenas_vedadas;

  typedef struct {
    string       tag;
    logic [13:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ecount   = 0;
  int   cyc      = 0;

  estacao_vedacao #(.SEAL_CYCLES(SEAL)) dut (
    .clk              (clk),
    .reset            (reset),
    .garrafa_pos      (garrafa_pos),
    .CR               (CR),
    .BZ               (BZ),
    .refill_ok        (refill_ok),
    .pega_rolha       (pega_rolha),
    .vedar            (vedar),
    .libera           (libera),
    .reabastecer      (reabastecer),
    .alarme_cr        (alarme_cr),
    .parado           (parado),
    .unidades_vedadas (unidades_vedadas),
    .dezenas_vedadas  (dezenas_vedadas)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d cycles", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] bcd_of(input int c);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(c / 10);
    u = 4'(c % 10);
    return {t, u};
  endfunction

  task automatic exp(input string tag, input logic [5:0] f);
    exp_t e;
    e.tag = tag;
    e.val = {f, bcd_of(ecount)};
    sb.push_back(e);
  endtask

  // PEGA, SEAL cycles of VEDA, LIBERA; the count shows +1 from the cycle after LIBERA.
  task automatic exp_service(input string tag, input logic [5:0] extra);
    exp({tag, "_pega"}, F_PEGA | extra);
    for (int i = 0; i < SEAL; i++) exp({tag, "_vedar"}, F_VEDA | extra);
    exp({tag, "_libera"}, F_LIB | extra);
    ecount = (ecount + 1) % 100;
  endtask

  task automatic tick();
    exp_t        e;
    logic [13:0] obs;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    obs = {pega_rolha, vedar, libera, reabastecer, parado, alarme_cr,
           dezenas_vedadas, unidades_vedadas};
    n_checks++;
    assert (unidades_vedadas <= 4'd9 && dezenas_vedadas <= 4'd9) else begin
      n_fail++;
      $error("FAIL bcd_digit cycle %0d: observed %h%h, required digits <= 9",
             cyc, dezenas_vedadas, unidades_vedadas);
    end
    n_checks++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty cycle %0d: observed %h, required a queued entry", cyc, obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s cycle %0d: observed %h, expected %h", e.tag, cyc, obs, e.val);
      end
    end
  endtask

  // One full bottle from IDLE: rise, service, then one IDLE cycle.
  task automatic bottle(input string tag);
    garrafa_pos = 1'b1;
    exp_service(tag, F_IDLE);
    exp({tag, "_idle"}, F_IDLE);
    for (int i = 0; i < SEAL + 2; i++) tick();
    garrafa_pos = 1'b0;
    tick();
  endtask

  initial begin
    // Reset with random inputs
    reset       = 1'b0;
    garrafa_pos = 1'($urandom_range(1, 0));
    CR          = 1'($urandom_range(1, 0));
    BZ          = 1'($urandom_range(1, 0));
    refill_ok   = 1'($urandom_range(1, 0));
    exp("reset", F_IDLE);
    tick();
    reset = 1'b1; garrafa_pos = 1'b0; CR = 1'b0; BZ = 1'b0; refill_ok = 1'b0;
    exp("post_reset", F_IDLE);
    tick();

    // Single bottle
    bottle("single");

    // Empty tray stalls, bottle stays pending, refill then service
    BZ = 1'b1; garrafa_pos = 1'b1;
    exp("empty_parado", F_PAR);
    tick();
    garrafa_pos = 1'b0;
    exp("empty_hold", F_PAR);
    exp("empty_hold", F_PAR);
    tick(); tick();
    refill_ok = 1'b1;
    exp("refill_reab", F_REAB);
    tick();
    refill_ok = 1'b0; BZ = 1'b0;
    exp("refill_assenta", F_IDLE);
    tick();
    exp("refill_idle", F_IDLE);
    tick();
    exp_service("pend_after_refill", F_IDLE);
    exp("pend_after_refill_idle", F_IDLE);
    for (int i = 0; i < SEAL + 3; i++) tick();

    // Tray still empty after refill: back to ESPERA, never PEGA
    BZ = 1'b1;
    exp("bz_espera", F_PAR);
    tick();
    refill_ok = 1'b1;
    exp("bz_reab", F_REAB);
    tick();
    refill_ok = 1'b0;
    exp("bz_assenta", F_IDLE);
    tick();
    exp("bz_idle", F_IDLE);
    tick();
    exp("bz_espera_again", F_PAR);
    tick();
    BZ = 1'b0; refill_ok = 1'b1;
    exp("bz_reab2", F_REAB);
    tick();
    refill_ok = 1'b0;
    exp("bz_assenta2", F_IDLE);
    exp("bz_idle2", F_IDLE);
    tick(); tick();

    // refill_ok ignored in IDLE without the low-cork alarm
    refill_ok = 1'b1;
    exp("gate_refill", F_IDLE);
    exp("gate_refill2", F_IDLE);
    tick(); tick();
    refill_ok = 1'b0;

    // Rise during VEDA is kept, rise during LIBERA is dropped
    exp_service("pend1", F_IDLE);
    exp("pend_gap", F_IDLE);
    exp_service("pend2", F_IDLE);
    exp("pend_idle", F_IDLE);
    exp("pend_no_third", F_IDLE);
    for (int i = 0; i < 2 * (SEAL + 2) + 3; i++) begin
      garrafa_pos = (i == 0) || (i == 2) || (i == SEAL + 2);
      tick();
    end
    garrafa_pos = 1'b0;

    // Low-cork alarm lags CR by one cycle and enables early refill
    CR = 1'b1;
    exp("cr_alarm", F_ALM);
    tick();
    refill_ok = 1'b1;
    exp("early_reab", F_REAB | F_ALM);
    tick();
    refill_ok = 1'b0; CR = 1'b0;
    exp("early_assenta", F_IDLE);
    exp("early_idle", F_IDLE);
    tick(); tick();

    // Reset in the middle of VEDA abandons the bottle
    garrafa_pos = 1'b1;
    exp("rst_pega", F_PEGA);
    exp("rst_veda", F_VEDA);
    exp("rst_veda", F_VEDA);
    tick(); tick(); tick();
    reset = 1'b0; garrafa_pos = 1'b0;
    ecount = 0;
    exp("rst_mid", F_IDLE);
    tick();
    reset = 1'b1;
    exp("rst_after", F_IDLE);
    exp("rst_after_no_libera", F_IDLE);
    tick(); tick();
    bottle("after_rst");

    // Wrap through 99 -> 00
    for (int b = 0; b < 100; b++) bottle("wrap");

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d entries left, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
